// File: rtl/sum_collector_if.sv
// Result/handshake bundle between the adder, sum_collector and its consumer.
// Statistics signals exist only when SUM_COLLECTOR_STATS_EN is defined.
interface sum_collector_if #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int ACC_W = 80
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             valid_i;
    logic [W:0]       sum_i;
    logic             is_odd_i;
    logic             ready_o;
    logic             valid_o;
    logic             ready_i;
    logic [W:0]       data_o;
    logic             odd_o;
    logic [CNT_W-1:0] count_o;
    logic             drop_o;
    logic             clear_i;
`ifdef SUM_COLLECTOR_STATS_EN
    logic [ACC_W-1:0] acc_o;
    logic [31:0]      odd_cnt_o;
`endif

    generate
        if (ACC_W < W + 1) begin : g_bad_acc_w
            $error("sum_collector_if: ACC_W must be >= W+1");
        end
    endgenerate

    modport master (
        output valid_i, sum_i, is_odd_i, ready_i, clear_i,
        input  ready_o, valid_o, data_o, odd_o, count_o, drop_o
`ifdef SUM_COLLECTOR_STATS_EN
        , input acc_o, odd_cnt_o
`endif
    );

    modport slave (
        input  valid_i, sum_i, is_odd_i, ready_i, clear_i,
        output ready_o, valid_o, data_o, odd_o, count_o, drop_o
`ifdef SUM_COLLECTOR_STATS_EN
        , output acc_o, odd_cnt_o
`endif
    );
endinterface

// File: rtl/sum_collector.sv
// First-word-fall-through buffer for adder results with sticky overflow flag.
// Define SUM_COLLECTOR_STATS_EN to add the running-sum / odd-count statistics.
module sum_collector #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int ACC_W = 80
) (
    input  logic              clk,
    input  logic              reset_n,
    sum_collector_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    generate
        if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sum_collector: DEPTH must be a power of two in 2..256");
        end
        if (ACC_W < W + 1) begin : g_bad_acc_w
            $error("sum_collector: ACC_W must be >= W+1");
        end
    endgenerate

    // Each entry holds {odd flag, sum}.
    logic [W+1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drop_q, drop_d;
    logic             full, push, pop, drop_ev;

    always_comb begin
        full     = (count_q == FULL_CNT);
        pop      = (count_q != '0) && bus.ready_i;
        push     = bus.valid_i && (!full || pop);
        drop_ev  = bus.valid_i && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        // A drop in the same cycle as clear_i keeps the flag set.
        drop_d   = drop_ev ? 1'b1 : (bus.clear_i ? 1'b0 : drop_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem_q[wr_ptr_q] <= {bus.is_odd_i, bus.sum_i};
        end
    end

    logic [W+1:0] head;
    assign head        = mem_q[rd_ptr_q];
    assign bus.data_o  = head[W:0];
    assign bus.odd_o   = head[W+1];
    assign bus.valid_o = (count_q != '0);
    assign bus.ready_o = !full;
    assign bus.count_o = count_q;
    assign bus.drop_o  = drop_q;

`ifdef SUM_COLLECTOR_STATS_EN
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [31:0]      odd_cnt_q, odd_cnt_d;

    // Clear zeroes the base first so a coincident push leaves only its own value.
    always_comb begin
        acc_d     = bus.clear_i ? '0 : acc_q;
        odd_cnt_d = bus.clear_i ? '0 : odd_cnt_q;
        if (push) begin
            acc_d = acc_d + ACC_W'(bus.sum_i);
            if (bus.is_odd_i && odd_cnt_d != 32'hFFFF_FFFF) begin
                odd_cnt_d = odd_cnt_d + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q     <= '0;
            odd_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            odd_cnt_q <= odd_cnt_d;
        end
    end

    assign bus.acc_o     = acc_q;
    assign bus.odd_cnt_o = odd_cnt_q;
`endif
endmodule

// File: tb/tb_sum_collector.sv
// Self-checking bench for sum_collector: directed scenarios plus a randomized
// run against a queue-based reference model (stats checked when SUM_COLLECTOR_STATS_EN).
module tb_sum_collector;
    localparam int W     = 64;
    localparam int DEPTH = 4;
    localparam int ACC_W = 80;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sum_collector_if #(.W(W), .DEPTH(DEPTH), .ACC_W(ACC_W)) bus ();

    sum_collector #(.W(W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    // Reference model: entries are {odd, sum}
    logic [W+1:0]     exp_q[$];
    logic             exp_drop;
    logic [ACC_W-1:0] exp_acc;
    logic [31:0]      exp_odd;

    task automatic model_edge();
        bit do_pop, do_push, is_full;
        if (!rst_n) begin
            exp_q.delete();
            exp_drop = 1'b0;
            exp_acc  = '0;
            exp_odd  = '0;
            return;
        end
        is_full = (exp_q.size() == DEPTH);
        do_pop  = (exp_q.size() > 0) && (bus.ready_i === 1'b1);
        do_push = (bus.valid_i === 1'b1) && (!is_full || do_pop);
        if (bus.clear_i === 1'b1) begin
            exp_drop = 1'b0;
            exp_acc  = '0;
            exp_odd  = '0;
        end
        if ((bus.valid_i === 1'b1) && is_full && !do_pop) exp_drop = 1'b1;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
            exp_q.push_back({bus.is_odd_i, bus.sum_i});
            exp_acc = exp_acc + ACC_W'(bus.sum_i);
            if (bus.is_odd_i && exp_odd != 32'hFFFF_FFFF) exp_odd = exp_odd + 1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_i  = 1'b0;
        bus.sum_i    = '0;
        bus.is_odd_i = 1'b0;
        bus.ready_i  = 1'b0;
        bus.clear_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.count_o); end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.valid_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", bus.ready_o); end
        checks++; if (bus.drop_o !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b want=0", bus.drop_o); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [W:0] v;
        v = 65'h1_0000_0000_0000_0001;
        bus.valid_i = 1'b1; bus.sum_i = v; bus.is_odd_i = 1'b1; bus.ready_i = 1'b1;
        step();
        idle_inputs(); bus.ready_i = 1'b1;
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got=%b want=1", bus.valid_o); end
        checks++; if (bus.data_o !== v) begin errors++; $display("FAIL single_data got=%h want=%h", bus.data_o, v); end
        checks++; if (bus.odd_o !== 1'b1) begin errors++; $display("FAIL single_odd got=%b want=1", bus.odd_o); end
        checks++; if (bus.count_o !== 3'd1) begin errors++; $display("FAIL single_count got=%0d want=1", bus.count_o); end
        step();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL single_valid_after got=%b want=0", bus.valid_o); end
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL single_count_after got=%0d want=0", bus.count_o); end
        idle_inputs();
        $display("test_single done");
    endtask

    task automatic test_overflow_drop();
        idle_inputs();
        for (int k = 1; k <= 5; k++) begin
            bus.valid_i = 1'b1; bus.sum_i = 65'(k); bus.is_odd_i = k[0];
            step();
            if (k == 4) begin
                checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL ovf_count4 got=%0d want=4", bus.count_o); end
                checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL ovf_ready4 got=%b want=0", bus.ready_o); end
                checks++; if (bus.drop_o !== 1'b0) begin errors++; $display("FAIL ovf_drop4 got=%b want=0", bus.drop_o); end
            end
        end
        checks++; if (bus.drop_o !== 1'b1) begin errors++; $display("FAIL ovf_drop5 got=%b want=1", bus.drop_o); end
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL ovf_count5 got=%0d want=4", bus.count_o); end
        idle_inputs(); bus.ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (bus.data_o !== 65'(k)) begin errors++; $display("FAIL ovf_drain got=%0d want=%0d", bus.data_o, k); end
            step();
        end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b want=0", bus.valid_o); end
        checks++; if (bus.drop_o !== 1'b1) begin errors++; $display("FAIL ovf_drop_sticky got=%b want=1", bus.drop_o); end
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        checks++; if (bus.drop_o !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b want=0", bus.drop_o); end
        idle_inputs();
        $display("test_overflow_drop done");
    endtask

    task automatic test_full_push_pop();
        int want[4] = '{2, 3, 4, 9};
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            bus.valid_i = 1'b1; bus.sum_i = 65'(k);
            step();
        end
        bus.valid_i = 1'b1; bus.sum_i = 65'd9; bus.ready_i = 1'b1;
        step();
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL fpp_count got=%0d want=4", bus.count_o); end
        checks++; if (bus.drop_o !== 1'b0) begin errors++; $display("FAIL fpp_drop got=%b want=0", bus.drop_o); end
        bus.valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.data_o !== 65'(want[k])) begin errors++; $display("FAIL fpp_drain got=%0d want=%0d", bus.data_o, want[k]); end
            step();
        end
        idle_inputs();
        $display("test_full_push_pop done");
    endtask

    task automatic test_wrap();
        int next_in = 10, next_out = 10, cyc = 0;
        bit ok_count = 1'b1;
        idle_inputs();
        while (next_out <= 29 && cyc < 200) begin
            bus.ready_i = cyc[0] ? 1'b0 : 1'b1;
            if (bus.valid_o === 1'b1 && bus.ready_i) begin
                checks++;
                if (bus.data_o !== 65'(next_out)) begin errors++; $display("FAIL wrap_data got=%0d want=%0d", bus.data_o, next_out); end
                else $display("wrap pop %0d", next_out);
                next_out++;
            end
            if (bus.count_o > 3'd4) ok_count = 1'b0;
            bus.valid_i = (next_in <= 29) && (bus.ready_o === 1'b1);
            bus.sum_i   = 65'(next_in);
            if (bus.valid_i) next_in++;
            step();
            cyc++;
        end
        checks++; if (next_out != 30) begin errors++; $display("FAIL wrap_timeout got=%0d want=30", next_out); end
        checks++; if (!ok_count) begin errors++; $display("FAIL wrap_count_bound got=over want=<=4"); end
        checks++; if (bus.drop_o !== 1'b0) begin errors++; $display("FAIL wrap_drop got=%b want=0", bus.drop_o); end
        idle_inputs();
        step();
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        for (int k = 1; k <= 5; k++) begin
            bus.valid_i = 1'b1; bus.sum_i = 65'(k);
            step();
        end
        bus.valid_i = 1'b0; bus.ready_i = 1'b1;
        step();
        checks++; if (bus.count_o !== 3'd3 || bus.drop_o !== 1'b1) begin errors++; $display("FAIL rmid_setup got=%0d/%b want=3/1", bus.count_o, bus.drop_o); end
        rst_n = 1'b0; bus.valid_i = 1'b1; bus.sum_i = 65'd77; bus.ready_i = 1'b1;
        step();
        rst_n = 1'b1; idle_inputs();
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL rmid_count got=%0d want=0", bus.count_o); end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b want=0", bus.valid_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b want=1", bus.ready_o); end
        checks++; if (bus.drop_o !== 1'b0) begin errors++; $display("FAIL rmid_drop got=%b want=0", bus.drop_o); end
        $display("test_reset_mid done");
    endtask

`ifdef SUM_COLLECTOR_STATS_EN
    task automatic test_stats();
        int   vals[3] = '{3, 4, 7};
        logic odds[3] = '{1'b1, 1'b0, 1'b1};
        idle_inputs();
        bus.clear_i = 1'b1; bus.ready_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.valid_i = 1'b1; bus.sum_i = 65'(vals[k]); bus.is_odd_i = odds[k];
            step();
        end
        bus.valid_i = 1'b0;
        checks++; if (bus.acc_o !== 80'd14) begin errors++; $display("FAIL stats_acc got=%0d want=14", bus.acc_o); end
        checks++; if (bus.odd_cnt_o !== 32'd2) begin errors++; $display("FAIL stats_odd got=%0d want=2", bus.odd_cnt_o); end
        bus.clear_i = 1'b1; bus.valid_i = 1'b1; bus.sum_i = 65'd6; bus.is_odd_i = 1'b0;
        step();
        idle_inputs();
        checks++; if (bus.acc_o !== 80'd6) begin errors++; $display("FAIL stats_clr_acc got=%0d want=6", bus.acc_o); end
        checks++; if (bus.odd_cnt_o !== 32'd0) begin errors++; $display("FAIL stats_clr_odd got=%0d want=0", bus.odd_cnt_o); end
        bus.ready_i = 1'b1;
        step(); step();
        idle_inputs();
        $display("test_stats done");
    endtask
`endif

    task automatic test_random();
        logic [W+1:0] h;
        for (int c = 0; c < 400; c++) begin
            checks++; if (bus.valid_o !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, bus.valid_o, exp_q.size() > 0); end
            checks++; if (bus.count_o !== 3'(exp_q.size())) begin errors++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, bus.count_o, exp_q.size()); end
            checks++; if (bus.ready_o !== (exp_q.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready c=%0d got=%b", c, bus.ready_o); end
            checks++; if (bus.drop_o !== exp_drop) begin errors++; $display("FAIL rnd_drop c=%0d got=%b want=%b", c, bus.drop_o, exp_drop); end
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                checks++; if (bus.data_o !== h[W:0] || bus.odd_o !== h[W+1]) begin errors++; $display("FAIL rnd_head c=%0d got=%h/%b want=%h/%b", c, bus.data_o, bus.odd_o, h[W:0], h[W+1]); end
            end
`ifdef SUM_COLLECTOR_STATS_EN
            checks++; if (bus.acc_o !== exp_acc || bus.odd_cnt_o !== exp_odd) begin errors++; $display("FAIL rnd_stats c=%0d got=%0d/%0d want=%0d/%0d", c, bus.acc_o, bus.odd_cnt_o, exp_acc, exp_odd); end
`endif
            bus.ready_i  = ($urandom_range(0, 99) < 45);
            bus.valid_i  = ($urandom_range(0, 99) < 65);
            bus.clear_i  = ($urandom_range(0, 99) < 5);
            bus.sum_i    = {1'($urandom), $urandom, $urandom};
            bus.is_odd_i = bus.sum_i[0];
            if (bus.ready_i && exp_q.size() > 0) $display("rnd pop c=%0d data=%h", c, bus.data_o);
            step();
        end
        idle_inputs();
        $display("test_random done");
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_overflow_drop();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
`ifdef SUM_COLLECTOR_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
